// File: rtl/module_operand_entry_pkg.sv
// Shared types and constants for the keypad operand entry unit.
package entry_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, HOLD = 2'd2} entry_state_t;
  localparam int DEC_MAX = 9;
endpackage

// File: rtl/module_operand_entry_key_edge.sv
// Rising-edge detector for a debounced key level; history resets high so a key
// already held at reset release never reads as a press.
module module_key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press
);
  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 1'b1;
    else        hist <= level;
  end

  assign press = level & ~hist;
endmodule

// File: rtl/module_operand_entry.sv
// Collects NUM_OPERANDS operands of up to NUM_DIGITS digits (MSD first) and
// hands the completed set downstream over a valid/ready handshake.
module module_operand_entry
  import entry_pkg::*;
#(
  parameter  int DIGIT_W      = 4,
  parameter  int NUM_DIGITS   = 3,
  parameter  int NUM_OPERANDS = 2,
  parameter  int DECIMAL_ONLY = 1,
  localparam int OPW  = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1,
  localparam int CW   = $clog2(NUM_DIGITS + 1),
  localparam int OP_W = NUM_DIGITS * DIGIT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DIGIT_W-1:0]           digit_in,
  input  logic                         key_digit,
  input  logic                         key_enter,
  input  logic                         clear,
  input  logic                         ops_ready,
  output logic                         ops_valid,
  output logic [NUM_OPERANDS*OP_W-1:0] operands,
  output logic [OPW-1:0]               op_index,
  output logic [CW-1:0]                digit_count,
  output logic                         digit_err
);
  entry_state_t    state, state_nxt;
  logic [OP_W-1:0] ops [NUM_OPERANDS];
  logic            dig_p, ent_p, dig_ok, last;
  logic            first, store, close, err_c;
  logic [OPW-1:0]  idx_cur;
  logic [OP_W-1:0] shifted;

  module_key_edge u_edge_digit (.clk(clk), .rst_n(rst_n), .level(key_digit), .press(dig_p));
  module_key_edge u_edge_enter (.clk(clk), .rst_n(rst_n), .level(key_enter), .press(ent_p));

  assign dig_ok    = (DECIMAL_ONLY == 0) || (int'(digit_in) <= DEC_MAX);
  // A new set always starts in operand 0, whatever op_index was left at.
  assign idx_cur   = (state == IDLE) ? '0 : op_index;
  assign last      = (idx_cur == OPW'(NUM_OPERANDS - 1));
  assign shifted   = (state == IDLE) ? OP_W'(digit_in)
                                     : ((ops[idx_cur] << DIGIT_W) | OP_W'(digit_in));
  assign ops_valid = (state == HOLD);

  always_comb begin
    state_nxt = state;
    first     = 1'b0;
    store     = 1'b0;
    close     = 1'b0;
    err_c     = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (dig_p && dig_ok) begin
            first     = 1'b1;
            store     = 1'b1;
            close     = (NUM_DIGITS == 1);
            state_nxt = ENTRY;
          end else if (dig_p) begin
            err_c = 1'b1;
          end
        end
        ENTRY: begin
          store = dig_p && dig_ok && (int'(digit_count) < NUM_DIGITS);
          err_c = dig_p && !dig_ok;
          // Digit and enter in one cycle still close only once.
          close = ent_p || (store && (int'(digit_count) + 1 >= NUM_DIGITS));
        end
        HOLD:    if (ops_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
      if (close) state_nxt = last ? HOLD : ENTRY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_index    <= '0;
      digit_count <= '0;
      digit_err   <= 1'b0;
      for (int k = 0; k < NUM_OPERANDS; k++) ops[k] <= '0;
    end else begin
      state     <= state_nxt;
      digit_err <= err_c;
      if (clear) begin
        op_index    <= '0;
        digit_count <= '0;
        for (int k = 0; k < NUM_OPERANDS; k++) ops[k] <= '0;
      end else begin
        if (first) for (int k = 0; k < NUM_OPERANDS; k++) ops[k] <= '0;
        if (store) ops[idx_cur] <= shifted;
        if (close) begin
          digit_count <= '0;
          op_index    <= last ? idx_cur : idx_cur + 1'b1;
        end else if (store) begin
          digit_count <= first ? CW'(1) : digit_count + 1'b1;
          op_index    <= idx_cur;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_flat
    assign operands[(k+1)*OP_W-1 -: OP_W] = ops[k];
  end
endmodule

// File: tb/tb_module_operand_entry.sv
// Scoreboard bench: stimulus queues expected operand sets / digit_err pulses,
// monitors pop and compare on each handshake or error pulse.
module tb_module_operand_entry;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  digit_in = 0;
  logic        key_digit = 0, key_enter = 0, clear = 0, ops_ready = 0;
  logic        ops_valid, digit_err;
  logic [23:0] operands;
  logic        op_index;
  logic [1:0]  digit_count;

  logic [3:0]  b_digit = 0;
  logic        b_kd = 0, b_ke = 0, b_ready = 0;
  logic        b_valid, b_err;
  logic [47:0] b_ops;
  logic [1:0]  b_idx;
  logic [2:0]  b_cnt;

  int checks = 0, fails = 0;
  logic [23:0] set_q[$];
  logic [47:0] bset_q[$];
  int          err_q[$];
  logic [23:0] snap;

  always #5 clk = ~clk;

  module_operand_entry dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .key_digit(key_digit),
    .key_enter(key_enter), .clear(clear), .ops_ready(ops_ready), .ops_valid(ops_valid),
    .operands(operands), .op_index(op_index), .digit_count(digit_count), .digit_err(digit_err));

  module_operand_entry #(.DIGIT_W(4), .NUM_DIGITS(4), .NUM_OPERANDS(3), .DECIMAL_ONLY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .digit_in(b_digit), .key_digit(b_kd),
    .key_enter(b_ke), .clear(1'b0), .ops_ready(b_ready), .ops_valid(b_valid),
    .operands(b_ops), .op_index(b_idx), .digit_count(b_cnt), .digit_err(b_err));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitors sample 2ns after the negedge, when stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (ops_valid && ops_ready) begin
      if (set_q.size() == 0) chk("unexpected_set", 64'(operands), 64'hDEAD);
      else chk("set_operands", 64'(operands), 64'(set_q.pop_front()));
    end
    if (digit_err) begin
      if (err_q.size() == 0) chk("unexpected_digit_err", 64'(digit_err), 64'h0);
      else begin void'(err_q.pop_front()); checks++; end
    end
    if (b_valid && b_ready) begin
      if (bset_q.size() == 0) chk("b_unexpected_set", 64'(b_ops), 64'hDEAD);
      else chk("b_set_operands", 64'(b_ops), 64'(bset_q.pop_front()));
    end
    if (b_err) chk("b_unexpected_digit_err", 64'(b_err), 64'h0);
  end

  task automatic drv(input logic kd, input logic ke, input logic [3:0] d);
    @(negedge clk); digit_in = d; key_digit = kd; key_enter = ke;
    @(negedge clk); key_digit = 0; key_enter = 0;
  endtask

  task automatic dig3(input logic [11:0] v);
    drv(1, 0, v[11:8]); drv(1, 0, v[7:4]); drv(1, 0, v[3:0]);
  endtask

  task automatic hs();
    chk("valid_before_hs", 64'(ops_valid), 64'h1);
    @(negedge clk); ops_ready = 1;
    @(negedge clk); ops_ready = 0;
    chk("valid_after_hs", 64'(ops_valid), 64'h0);
  endtask

  task automatic bdrv(input logic kd, input logic ke, input logic [3:0] d);
    @(negedge clk); b_digit = d; b_kd = kd; b_ke = ke;
    @(negedge clk); b_kd = 0; b_ke = 0;
  endtask

  initial begin
    #12;
    chk("rst_operands", 64'(operands), 64'h0);
    chk("rst_valid", 64'(ops_valid), 64'h0);
    chk("rst_idx_cnt_err", 64'({op_index, digit_count, digit_err}), 64'h0);
    @(negedge clk); rst_n = 1;

    // Two full operands, auto-close at NUM_DIGITS.
    set_q.push_back(24'h456123);
    dig3(12'h123);
    chk("t1_idx_after_op0", 64'(op_index), 64'h1);
    dig3(12'h456);
    hs();

    // Invalid digits in IDLE and ENTRY.
    set_q.push_back(24'h123045);
    err_q.push_back(1); drv(1, 0, 4'hB);
    chk("t3_idle_stays", 64'({ops_valid, digit_count}), 64'h0);
    drv(1, 0, 4'h4);
    err_q.push_back(1); drv(1, 0, 4'hA);
    chk("t3_cnt_unchanged", 64'(digit_count), 64'h1);
    drv(1, 0, 4'h5); drv(0, 1, 0);
    dig3(12'h123);
    hs();

    // Early termination with enter.
    set_q.push_back(24'h098007);
    drv(1, 0, 4'h7); drv(0, 1, 0);
    drv(1, 0, 4'h9); drv(1, 0, 4'h8); drv(0, 1, 0);
    chk("t2_operands", 64'(operands), 64'h098007);
    hs();

    // HOLD stability with presses ignored.
    set_q.push_back(24'h543876);
    dig3(12'h876); dig3(12'h543);
    snap = operands;
    chk("t4_hold_value", 64'(snap), 64'h543876);
    drv(1, 0, 4'h7); drv(0, 1, 0); drv(1, 0, 4'hA);
    repeat (4) @(negedge clk);
    chk("t4_stable_ops", 64'(operands), 64'(snap));
    chk("t4_stable_valid", 64'(ops_valid), 64'h1);
    hs();
    chk("t4_retained", 64'(operands), 64'h543876);

    // Digit+enter together.
    set_q.push_back(24'h234015);
    drv(1, 0, 4'h1); drv(1, 1, 4'h5);
    chk("t6_op0", 64'(operands[11:0]), 64'h015);
    chk("t6_idx_cnt", 64'({op_index, digit_count}), 64'h4);
    drv(1, 0, 4'h2); drv(1, 0, 4'h3); drv(1, 1, 4'h4);
    hs();

    // Full + enter closes once; empty operand via enter.
    set_q.push_back(24'h000789);
    drv(1, 0, 4'h7); drv(1, 0, 4'h8); drv(1, 1, 4'h9);
    chk("t6b_no_skip", 64'({ops_valid, op_index, digit_count}), 64'h4);
    drv(0, 1, 0);
    hs();

    // Clear mid-operand1.
    dig3(12'h123); drv(1, 0, 4'h4); drv(1, 0, 4'h5);
    chk("t5_pre_clear", 64'({op_index, digit_count}), 64'h6);
    @(negedge clk); clear = 1;
    @(negedge clk); clear = 0;
    chk("t5_clear_ops", 64'(operands), 64'h0);
    chk("t5_clear_state", 64'({ops_valid, op_index, digit_count}), 64'h0);

    // Async reset mid-entry with key held through release.
    drv(1, 0, 4'h1); drv(1, 0, 4'h2);
    chk("t5_pre_rst_cnt", 64'(digit_count), 64'h2);
    digit_in = 4'h3; key_digit = 1;
    #2 rst_n = 0;
    #1;
    chk("t5_rst_ops", 64'(operands), 64'h0);
    chk("t5_rst_state", 64'({ops_valid, op_index, digit_count, digit_err}), 64'h0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("t5_held_key_no_press", 64'({op_index, digit_count}), 64'h0);
    key_digit = 0;
    set_q.push_back(24'h654321);
    dig3(12'h321); dig3(12'h654);
    hs();

    // Wider configuration, hex digits accepted.
    bset_q.push_back(48'h000F_0012_ABCD);
    bdrv(1, 0, 4'hA); bdrv(1, 0, 4'hB); bdrv(1, 0, 4'hC); bdrv(1, 0, 4'hD);
    chk("b_autoclose", 64'({b_idx, b_cnt}), 64'h8);
    bdrv(1, 0, 4'h1); bdrv(1, 0, 4'h2); bdrv(0, 1, 0);
    bdrv(1, 0, 4'hF); bdrv(0, 1, 0);
    chk("b_valid", 64'(b_valid), 64'h1);
    @(negedge clk); b_ready = 1;
    @(negedge clk); b_ready = 0;
    chk("b_valid_after_hs", 64'(b_valid), 64'h0);

    repeat (3) @(negedge clk);
    chk("set_q_drained", 64'(set_q.size()), 64'h0);
    chk("err_q_drained", 64'(err_q.size()), 64'h0);
    chk("bset_q_drained", 64'(bset_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
